// File: rtl/m_clk_pkg.sv
// Shared definitions for the m_clk_div clock divider: default widths,
// the minimum legal divisor and the divider FSM state encoding.
package m_clk_pkg;

    localparam int DEF_DIV_W = 8;
    localparam int MIN_DIV   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage : m_clk_pkg

// File: rtl/m_inv.sv
// Clock-path inverter. The library mapping for the clock-path inverter lives
// in this one file; here it is a plain inversion.
module m_inv (
    input  logic a,
    output logic y
);

    assign y = ~a;

endmodule : m_inv

// File: rtl/m_clk_div.sv
// Glitch-free programmable integer clock divider. Start/stop and ratio changes
// act only on a period boundary; clk_out is driven straight from a flop.
//
// div_req/div_ack handshake: the requester raises div_req with a stable div_val
// and holds both until div_ack. div_val is sampled in IDLE or at the boundary
// (cnt == D-1). div_ack is a registered one-cycle pulse that is high during
// the first cycle in which the new divisor is in effect. The requester drops
// div_req in the cycle after div_ack. If div_req falls before it is sampled,
// the request is dropped and no div_ack is given.
module m_clk_div
    import m_clk_pkg::*;
#(
    parameter int DIV_W   = DEF_DIV_W,
    parameter int DEF_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_req,
    input  logic [DIV_W-1:0] div_val,
    output logic             div_ack,
    output logic             clk_out,
    output logic             clk_out_n,
    output logic             busy
);

    state_t           state, state_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic [DIV_W-1:0] div_q, div_q_nxt;
    logic             clk_out_nxt;
    logic             ack_nxt;

    logic [DIV_W:0]   div_eff;
    logic [DIV_W:0]   half;
    logic [DIV_W:0]   cnt_inc;
    logic             boundary;
    logic             req_ok;

    // Divisor arithmetic is done one bit wider so D = 2^DIV_W-1 does not wrap.
    always_comb begin
        div_eff  = (div_q < DIV_W'(MIN_DIV)) ? (DIV_W+1)'(MIN_DIV) : {1'b0, div_q};
        half     = (div_eff + (DIV_W+1)'(1)) >> 1;
        cnt_inc  = {1'b0, cnt} + (DIV_W+1)'(1);
        boundary = ({1'b0, cnt} == (div_eff - (DIV_W+1)'(1)));
        // Ignoring a request in the ack cycle keeps div_ack from repeating.
        req_ok   = div_req && !div_ack;
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        div_q_nxt   = div_q;
        clk_out_nxt = clk_out;
        ack_nxt     = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_nxt     = '0;
                clk_out_nxt = 1'b0;
                if (req_ok) begin
                    div_q_nxt = div_val;
                    ack_nxt   = 1'b1;
                end
                if (en) begin
                    state_nxt   = RUN;
                    clk_out_nxt = 1'b1;
                end
            end
            RUN: begin
                if (boundary) begin
                    cnt_nxt = '0;
                    if (req_ok) begin
                        div_q_nxt = div_val;
                        ack_nxt   = 1'b1;
                    end
                    if (en) begin
                        clk_out_nxt = 1'b1;
                    end else begin
                        state_nxt   = IDLE;
                        clk_out_nxt = 1'b0;
                    end
                end else begin
                    cnt_nxt     = cnt_inc[DIV_W-1:0];
                    clk_out_nxt = (cnt_inc < half);
                end
            end
            default: begin
                state_nxt   = IDLE;
                cnt_nxt     = '0;
                clk_out_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            div_q   <= DIV_W'(DEF_DIV);
            clk_out <= 1'b0;
            div_ack <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            div_q   <= div_q_nxt;
            clk_out <= clk_out_nxt;
            div_ack <= ack_nxt;
        end
    end

    assign busy = (state != IDLE);

    m_inv u_inv (
        .a (clk_out),
        .y (clk_out_n)
    );

endmodule : m_clk_div
